// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding and divider iteration count.
package ex_muldiv_pkg;

  localparam int RegDataWidth = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;

  // Divider iteration counter width and iterations per division.
  localparam int              CNT_W     = 6;
  localparam logic [CNT_W-1:0] DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// step. A zero divisor yields an all-ones quotient and remainder = dividend.
module ex_muldiv_div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int data_width = RegDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [data_width-1:0] dividend,
  input  logic [data_width-1:0] divisor,
  output logic [data_width-1:0] quotient,
  output logic [data_width-1:0] remainder,
  output logic                  last
);

  logic [data_width-1:0] rem_q;
  logic [data_width-1:0] quo_q;
  logic [data_width-1:0] dsr_q;
  logic [data_width-1:0] diff;
  logic [data_width:0]   rem_shift;
  logic [CNT_W-1:0]      cnt_q;
  logic                  fits;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // The true difference is below the divisor when it fits, so the low
  // bits of a plain subtraction are exact.
  always_comb begin
    rem_shift = {rem_q, quo_q[data_width-1]};
    fits      = (rem_shift >= {1'b0, dsr_q});
    diff      = rem_shift[data_width-1:0] - dsr_q;
  end

  // Load operands, then shift in one quotient bit per step until the count expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= DIV_ITERS;
    end else if (step && (cnt_q != '0)) begin
      rem_q <= fits ? diff : rem_shift[data_width-1:0];
      quo_q <= {quo_q[data_width-2:0], fits};
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO multiply/divide unit. MULT/MULTU take one busy cycle,
// DIV/DIVU take 32 iterations; results are presented with a one-cycle
// hilo_we strobe in DONE and held until the next completed operation.
//
// state  | meaning
// IDLE   | waiting for start with a valid op
// MUL    | one cycle computing the 64-bit product
// DIV    | 32 restoring-division iterations
// DONE   | result on hi_out/lo_out, hilo_we strobe
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int data_width = RegDataWidth,
  parameter int op_width   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [op_width-1:0]   md_op,
  input  logic [data_width-1:0] opa,
  input  logic [data_width-1:0] opb,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  hilo_we,
  output logic [data_width-1:0] hi_out,
  output logic [data_width-1:0] lo_out
);

  localparam int PW = 2 * data_width;

  state_t state, state_nxt;

  logic                  op_valid;
  logic                  op_is_div;
  logic                  op_signed;
  logic                  accept;
  logic [data_width-1:0] opa_q;
  logic [data_width-1:0] opb_q;
  logic                  signed_q;
  logic                  div_q;
  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         b_ext;
  logic [PW-1:0]         prod_q;
  logic [data_width-1:0] opa_mag;
  logic [data_width-1:0] opb_mag;
  logic [data_width-1:0] quo;
  logic [data_width-1:0] rem;
  logic                  div_last;
  logic                  div_by_zero;
  logic                  q_neg;
  logic                  r_neg;
  logic [data_width-1:0] res_hi;
  logic [data_width-1:0] res_lo;
  logic [data_width-1:0] hi_q;
  logic [data_width-1:0] lo_q;

  // Decode md_op; unknown codes are simply never accepted.
  always_comb begin
    op_valid  = (md_op == op_width'(OP_MULT)) || (md_op == op_width'(OP_MULTU)) ||
                (md_op == op_width'(OP_DIV))  || (md_op == op_width'(OP_DIVU));
    op_is_div = (md_op == op_width'(OP_DIV))  || (md_op == op_width'(OP_DIVU));
    op_signed = (md_op == op_width'(OP_MULT)) || (md_op == op_width'(OP_DIV));
  end

  // Reset and flush both win over start, so neither can let an op in.
  assign accept = (state == S_IDLE) && start && op_valid && !flush && !rst;

  assign opa_mag = (op_signed && opa[data_width-1]) ? -opa : opa;
  assign opb_mag = (op_signed && opb[data_width-1]) ? -opb : opb;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) state_nxt = op_is_div ? S_DIV : S_MUL;
        S_MUL:  state_nxt = S_DONE;
        S_DIV:  if (div_last) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: stall while accepting or busy, strobe only in an uncancelled DONE.
  always_comb begin
    stall_req = accept || (state == S_MUL) || (state == S_DIV);
    hilo_we   = (state == S_DONE) && !flush && !rst;
  end

  // Capture operands and op flavour at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      signed_q <= 1'b0;
      div_q    <= 1'b0;
    end else if (accept) begin
      opa_q    <= opa;
      opb_q    <= opb;
      signed_q <= op_signed;
      div_q    <= op_is_div;
    end
  end

  // Sign- or zero-extending to full width makes the low half of one
  // unsigned multiply correct for both MULT and MULTU.
  assign a_ext = {{data_width{signed_q & opa_q[data_width-1]}}, opa_q};
  assign b_ext = {{data_width{signed_q & opb_q[data_width-1]}}, opb_q};

  // Product register, written during the single MUL cycle.
  always_ff @(posedge clk) begin
    if (rst)                 prod_q <= '0;
    else if (state == S_MUL) prod_q <= a_ext * b_ext;
  end

  ex_muldiv_div_iter #(.data_width(data_width)) div_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == S_DIV),
    .dividend  (opa_mag),
    .divisor   (opb_mag),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  // Select the finished result and restore signs for DIV. Divide by zero
  // reports the raw dividend, not its magnitude.
  always_comb begin
    div_by_zero = (opb_q == '0);
    q_neg       = signed_q && (opa_q[data_width-1] ^ opb_q[data_width-1]);
    r_neg       = signed_q && opa_q[data_width-1];
    if (!div_q) begin
      res_hi = prod_q[PW-1:data_width];
      res_lo = prod_q[data_width-1:0];
    end else if (div_by_zero) begin
      res_hi = opa_q;
      res_lo = '1;
    end else begin
      res_hi = r_neg ? -rem : rem;
      res_lo = q_neg ? -quo : quo;
    end
  end

  // HI/LO hold registers, updated on the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_we) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

  assign hi_out = hilo_we ? res_hi : hi_q;
  assign lo_out = hilo_we ? res_lo : lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  md_op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  ex_muldiv #(.data_width(32), .op_width(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .md_op     (md_op),
    .opa       (opa),
    .opb       (opb),
    .flush     (flush),
    .stall_req (stall_req),
    .hilo_we   (hilo_we),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic: MIPS HI/LO semantics from plain integer math.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: ;
    endcase
  endtask

  // Issue one op from IDLE and check stall, latency, strobe and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int          lat;
    model(op, a, b, eh, el);
    lat   = op[1] ? 33 : 2;
    start = 1'b1; md_op = op; opa = a; opb = b;
    #1;
    chk("accept_stall", stall_req, 1);
    chk("accept_we", hilo_we, 0);
    tick();
    start = 1'b0; md_op = 3'($urandom); opa = $urandom; opb = $urandom;
    for (int c = 1; c < lat; c++) begin
      #1;
      chk("busy_stall", stall_req, 1);
      chk("busy_we", hilo_we, 0);
      chk("busy_hi_held", hi_out, exp_hi);
      tick();
    end
    #1;
    chk("done_we", hilo_we, 1);
    chk("done_stall", stall_req, 0);
    chk("done_hi", hi_out, eh);
    chk("done_lo", lo_out, el);
    exp_hi = eh;
    exp_lo = el;
    tick();
    #1;
    chk("after_we", hilo_we, 0);
    chk("after_hi", hi_out, exp_hi);
    chk("after_lo", lo_out, exp_lo);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("idle_we", hilo_we, 0);
      chk("idle_stall", stall_req, 0);
      chk("idle_hi", hi_out, exp_hi);
      chk("idle_lo", lo_out, exp_lo);
      tick();
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; md_op = '0; opa = '0; opb = '0;
    tick(); tick(); tick();
    start = 1'b1;
    #1;
    chk("rst_stall", stall_req, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Directed corner cases, each also checked against literal values.
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_lo", lo_out, 32'h0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7);
    chk("divu_hi", hi_out, 32'd2);
    chk("divu_lo", lo_out, 32'd14);
    run_op(3'd3, 32'h1234, 32'd0);
    chk("divz_hi", hi_out, 32'h1234);
    chk("divz_lo", lo_out, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_hi", hi_out, 32'd0);
    chk("ovf_lo", lo_out, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0);
    chk("sdivz_hi", hi_out, 32'hFFFF_FFFB);

    // Invalid op code is ignored.
    start = 1'b1; md_op = 3'd5; opa = 32'd9; opb = 32'd9;
    #1;
    chk("badop_stall", stall_req, 0);
    tick();
    start = 1'b0;
    idle_check(3);

    // Flush beats start in IDLE.
    start = 1'b1; md_op = 3'd0; flush = 1'b1; opa = 32'd3; opb = 32'd4;
    #1;
    chk("flushstart_stall", stall_req, 0);
    tick();
    start = 1'b0; flush = 1'b0;
    idle_check(3);

    // Start during DONE is not taken; the following IDLE cycle takes it.
    start = 1'b1; md_op = 3'd0; opa = 32'd7; opb = 32'd9;
    #1;
    chk("b2b_accept1", stall_req, 1);
    tick();
    start = 1'b0;
    #1;
    chk("b2b_mul1", stall_req, 1);
    tick();
    start = 1'b1; md_op = 3'd1; opa = 32'd11; opb = 32'd13;
    #1;
    chk("b2b_done_we", hilo_we, 1);
    chk("b2b_done_lo", lo_out, 32'd63);
    chk("b2b_done_stall", stall_req, 0);
    exp_hi = 32'd0; exp_lo = 32'd63;
    tick();
    #1;
    chk("b2b_accept2", stall_req, 1);
    chk("b2b_idle_we", hilo_we, 0);
    tick();
    start = 1'b0;
    #1;
    chk("b2b_mul2", stall_req, 1);
    tick();
    #1;
    chk("b2b_done2_we", hilo_we, 1);
    chk("b2b_done2_lo", lo_out, 32'd143);
    exp_lo = 32'd143;
    tick();
    idle_check(2);

    // Flush a DIV at N+10.
    start = 1'b1; md_op = 3'd2; opa = $urandom; opb = $urandom | 32'd1;
    #1;
    chk("fl_accept", stall_req, 1);
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("fl_we", hilo_we, 0);
    tick();
    flush = 1'b0;
    idle_check(40);

    // Reset at N+5 of a DIV.
    run_op(3'd3, 32'd100, 32'd7);
    start = 1'b1; md_op = 3'd2; opa = $urandom; opb = $urandom | 32'd1;
    #1;
    chk("rm_accept", stall_req, 1);
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    idle_check(40);
    run_op(3'd0, 32'd5, 32'd6);
    chk("rm_mult_hi", hi_out, 32'd0);
    chk("rm_mult_lo", lo_out, 32'd30);

    // Randomized operations against the model.
    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
